apu_sound_scheduler: RTL and testbench

Sequences the shared square-wave tone channel of the APU among the three game sound events: eat, hit and die. It sits between the collision-to-sound trigger stage and the tone oscillator. It edge-detects the three sound requests, queues them, and arbitrates them by fixed priority with preemption. It then plays each sound as a short note sequence timed in video frames, driving the period and enable of the downstream oscillator.

---
 rtl/apu_sound_scheduler.sv | 146 ++++++++++++++
 tb/tb_apu_sound_scheduler.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/apu_sound_scheduler.sv
// Shares the APU square-wave tone channel among the eat/hit/die sound events.
// Requests are edge-detected, queued, and played by fixed priority with preemption.
module apu_sound_scheduler #(
  parameter int LEN_SCALE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_end,
  input  logic       eat_req,
  input  logic       hit_req,
  input  logic       die_req,
  input  logic       mute,
  output logic       tone_en,
  output logic [7:0] tone_period,
  output logic [1:0] sound_id,
  output logic [2:0] step,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t     state, state_n;
  logic [2:0] req, req_q, pending, pending_n, clr;
  logic [1:0] snd, snd_n, hi_id;
  logic [2:0] stp, stp_n;
  logic [4:0] cnt, cnt_n;
  logic       mute_q;

  function automatic logic [4:0] frames_of(input logic [1:0] s);
    logic [4:0] base;
    case (s)
      2'd1:    base = 5'd2;
      2'd2:    base = 5'd3;
      2'd3:    base = 5'd4;
      default: base = 5'd0;
    endcase
    return base * 5'(LEN_SCALE);
  endfunction

  function automatic logic [2:0] last_step(input logic [1:0] s);
    case (s)
      2'd1:    return 3'd3;
      2'd2:    return 3'd2;
      2'd3:    return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [7:0] rom(input logic [1:0] s, input logic [2:0] st);
    logic [7:0] p;
    p = 8'd0;
    case (s)
      2'd1: case (st)
        3'd0: p = 8'd60;  3'd1: p = 8'd50;  3'd2: p = 8'd40;  3'd3: p = 8'd30;
        default: p = 8'd0;
      endcase
      2'd2: case (st)
        3'd0: p = 8'd100; 3'd1: p = 8'd120; 3'd2: p = 8'd140;
        default: p = 8'd0;
      endcase
      2'd3: case (st)
        3'd0: p = 8'd80;  3'd1: p = 8'd90;  3'd2: p = 8'd100;
        3'd3: p = 8'd120; 3'd4: p = 8'd140; 3'd5: p = 8'd180;
        default: p = 8'd0;
      endcase
      default: p = 8'd0;
    endcase
    return p;
  endfunction

  assign req = {die_req, hit_req, eat_req};

  // sound_id doubles as priority rank, so the highest pending id wins
  assign hi_id = pending[2] ? 2'd3 : pending[1] ? 2'd2 : pending[0] ? 2'd1 : 2'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      snd     <= 2'd0;
      stp     <= 3'd0;
      cnt     <= 5'd0;
      pending <= 3'd0;
      req_q   <= 3'd0;
      mute_q  <= 1'b0;
    end else begin
      state   <= state_n;
      snd     <= snd_n;
      stp     <= stp_n;
      cnt     <= cnt_n;
      pending <= pending_n;
      req_q   <= req;
      mute_q  <= mute;
    end
  end

  always_comb begin
    state_n = state;
    snd_n   = snd;
    stp_n   = stp;
    cnt_n   = cnt;
    clr     = 3'd0;
    case (state)
      IDLE, PLAY: begin
        // from IDLE any pending sound starts; in PLAY only a strictly higher one preempts
        if (hi_id != 2'd0 && (state == IDLE || hi_id > snd)) begin
          state_n = PLAY;
          snd_n   = hi_id;
          stp_n   = 3'd0;
          cnt_n   = frames_of(hi_id);
          clr     = (hi_id == 2'd3) ? 3'b100 : (hi_id == 2'd2) ? 3'b010 : 3'b001;
        end else if (state == PLAY && frame_end) begin
          if (cnt == 5'd1) begin
            if (stp == last_step(snd)) begin
              state_n = GAP;
            end else begin
              stp_n = stp + 3'd1;
              cnt_n = frames_of(snd);
            end
          end else begin
            cnt_n = cnt - 5'd1;
          end
        end
      end
      GAP: begin
        if (frame_end) begin
          state_n = IDLE;
          snd_n   = 2'd0;
          stp_n   = 3'd0;
          cnt_n   = 5'd0;
        end
      end
      default: state_n = IDLE;
    endcase
    // a fresh edge on the starting sound wins over its clear
    pending_n = (pending & ~clr) | (req & ~req_q);
  end

  always_comb begin
    tone_en     = (state == PLAY) && !mute_q;
    tone_period = (state == PLAY) ? rom(snd, stp) : 8'd0;
    sound_id    = snd;
    step        = stp;
    busy        = (state != IDLE);
  end

endmodule

// File: tb/tb_apu_sound_scheduler.sv
// Directed bench for apu_sound_scheduler: playback, preemption, queuing, held
// levels, set/clear collision, mute and reset, with hand-computed expectations.
module tb_apu_sound_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_end = 1'b0;
  logic       eat_req = 1'b0, hit_req = 1'b0, die_req = 1'b0, mute = 1'b0;
  logic       tone_en, busy;
  logic [7:0] tone_period;
  logic [1:0] sound_id;
  logic [2:0] step;

  int errors = 0;
  int checks = 0;

  apu_sound_scheduler #(.LEN_SCALE(1)) dut (
    .clk(clk), .reset(reset), .frame_end(frame_end),
    .eat_req(eat_req), .hit_req(hit_req), .die_req(die_req), .mute(mute),
    .tone_en(tone_en), .tone_period(tone_period), .sound_id(sound_id),
    .step(step), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // each frame: 7 quiet cycles then a one-cycle frame_end pulse
  task automatic frames(input int n);
    repeat (n) begin
      idle(7);
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic en, input logic [1:0] id,
                         input logic [2:0] st, input logic [7:0] per, input logic bz);
    chk({tag, ".tone_en"}, 32'(tone_en), 32'(en));
    chk({tag, ".sound_id"}, 32'(sound_id), 32'(id));
    chk({tag, ".step"}, 32'(step), 32'(st));
    chk({tag, ".tone_period"}, 32'(tone_period), 32'(per));
    chk({tag, ".busy"}, 32'(busy), 32'(bz));
  endtask

  initial begin
    idle(3);
    reset = 1'b0;
    tick();
    chk_out("reset", 0, 0, 0, 0, 0);

    // eat from idle
    eat_req = 1'b1;
    tick();
    chk_out("eat_t1", 0, 0, 0, 0, 0);
    tick();
    chk_out("eat_start", 1, 1, 0, 60, 1);
    frames(1); chk_out("eat_s0b", 1, 1, 0, 60, 1);
    frames(1); chk_out("eat_s1", 1, 1, 1, 50, 1);
    frames(2); chk_out("eat_s2", 1, 1, 2, 40, 1);
    frames(2); chk_out("eat_s3", 1, 1, 3, 30, 1);
    frames(1); chk_out("eat_s3b", 1, 1, 3, 30, 1);
    frames(1); chk("eat_gap.busy", 32'(busy), 1); chk("eat_gap.en", 32'(tone_en), 0);
    chk("eat_gap.id", 32'(sound_id), 1);
    frames(1); chk_out("eat_idle", 0, 0, 0, 0, 0);
    eat_req = 1'b0;
    idle(2);

    // preemption of eat by die
    eat_req = 1'b1;
    idle(2);
    frames(2); chk_out("pre_eat_s1", 1, 1, 1, 50, 1);
    die_req = 1'b1;
    tick(); chk_out("pre_edge", 1, 1, 1, 50, 1);
    tick(); chk_out("pre_die", 1, 3, 0, 80, 1);
    frames(4); chk_out("die_s1", 1, 3, 1, 90, 1);
    frames(20); chk("die_gap.en", 32'(tone_en), 0); chk("die_gap.id", 32'(sound_id), 3);
    chk("die_gap.busy", 32'(busy), 1);
    frames(1); idle(3); chk_out("no_resume", 0, 0, 0, 0, 0);
    eat_req = 1'b0; die_req = 1'b0;
    idle(2);

    // queuing behind die
    die_req = 1'b1;
    idle(2); chk_out("q_die", 1, 3, 0, 80, 1);
    hit_req = 1'b1; eat_req = 1'b1;
    tick();
    frames(24); chk("q_gap.id", 32'(sound_id), 3);
    frames(1); chk("q_idle.busy", 32'(busy), 0);
    tick(); chk_out("q_hit", 1, 2, 0, 100, 1);
    frames(3); chk_out("q_hit_s1", 1, 2, 1, 120, 1);
    frames(3); chk_out("q_hit_s2", 1, 2, 2, 140, 1);
    frames(3); chk("q_hit_gap.id", 32'(sound_id), 2);
    frames(1); tick(); chk_out("q_eat", 1, 1, 0, 60, 1);
    frames(9); chk_out("q_done", 0, 0, 0, 0, 0);
    die_req = 1'b0; eat_req = 1'b0;
    hit_req = 1'b0;
    idle(2);

    // held level: one hit only
    hit_req = 1'b1;
    idle(2); chk_out("held_hit", 1, 2, 0, 100, 1);
    frames(10); chk_out("held_done", 0, 0, 0, 0, 0);
    frames(490); chk("held_noretrig.busy", 32'(busy), 0);
    hit_req = 1'b0; tick(); hit_req = 1'b1;
    idle(2); chk_out("retrig_hit", 1, 2, 0, 100, 1);
    frames(10); chk("retrig_done.busy", 32'(busy), 0);
    hit_req = 1'b0;
    idle(2);

    // simultaneous edges play die, hit, eat
    eat_req = 1'b1; hit_req = 1'b1; die_req = 1'b1;
    idle(2); chk("sim_first.id", 32'(sound_id), 3);
    frames(25); tick(); chk("sim_second.id", 32'(sound_id), 2);
    frames(10); tick(); chk("sim_third.id", 32'(sound_id), 1);
    frames(9); chk("sim_done.busy", 32'(busy), 0);
    eat_req = 1'b0; hit_req = 1'b0; die_req = 1'b0;
    idle(2);

    // new eat edge exactly as queued eat starts: eat replays
    die_req = 1'b1; eat_req = 1'b1;
    tick(); eat_req = 1'b0;
    tick(); chk("col_die.id", 32'(sound_id), 3);
    frames(25); chk("col_idle.busy", 32'(busy), 0);
    eat_req = 1'b1;
    tick(); chk_out("col_eat", 1, 1, 0, 60, 1);
    frames(9); tick(); chk_out("col_replay", 1, 1, 0, 60, 1);
    frames(9); idle(3); chk("col_done.busy", 32'(busy), 0);
    eat_req = 1'b0; die_req = 1'b0;
    idle(2);

    // mute during hit
    hit_req = 1'b1;
    idle(2); chk("mute_pre.en", 32'(tone_en), 1);
    mute = 1'b1;
    tick(); chk_out("mute_on", 0, 2, 0, 100, 1);
    frames(3); chk_out("mute_s1", 0, 2, 1, 120, 1);
    mute = 1'b0;
    tick(); chk_out("mute_off", 1, 2, 1, 120, 1);
    frames(7); chk("mute_done.busy", 32'(busy), 0);
    hit_req = 1'b0;
    idle(2);

    // reset mid-die with die_req held through reset
    die_req = 1'b1;
    idle(2);
    frames(5); chk_out("rst_pre", 1, 3, 1, 90, 1);
    reset = 1'b1;
    tick(); chk_out("rst_mid", 0, 0, 0, 0, 0);
    tick(); reset = 1'b0;
    tick(); chk("rst_rel.busy", 32'(busy), 0);
    tick(); chk_out("rst_replay", 1, 3, 0, 80, 1);
    frames(25); idle(3); chk_out("rst_once", 0, 0, 0, 0, 0);
    die_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
